branch_predict_ctrl: RTL and testbench

Branch prediction and redirect controller for the 5-stage RV32 pipeline. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Lookup happens in IF. Each table entry is trained in EX from the outcome produced by the branch decision logic. On a misprediction it issues the flush/redirect that the hazard unit consumes. It also keeps branch and mispredict statistics counters.

---
 rtl/branch_predict_ctrl.sv | 90 +++++++++
 tb/tb_branch_predict_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit saturating counters: IF lookup, EX training,
// mispredict flush/redirect, and saturating branch/mispredict statistics.
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_n,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredTargetF,
  input  logic             StallE,
  input  logic             IsBranchE,
  input  logic             BranchE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      BrTargetE,
  input  logic             PredTakenE,
  output logic             FlushMispredict,
  output logic [31:0]      RedirectPC,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             res_act, mispred;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];

  // No write-to-read bypass: lookup always sees the registered table.
  assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? target_q[idx_f] : 32'h0;

  assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign res_act = IsBranchE && !StallE;
  assign mispred = res_act && (BranchE != PredTakenE);

  assign FlushMispredict = mispred;
  assign RedirectPC      = res_act ? (BranchE ? BrTargetE : PCE + 32'd4) : 32'h0;

  always_ff @(posedge CPU_CLK or negedge CPU_RST_n) begin
    if (!CPU_RST_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (res_act) begin
      if (hit_e) begin
        if (BranchE) begin
          target_q[idx_e] <= BrTargetE;
          if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        // Only taken branches allocate; the new entry starts weakly taken.
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= BrTargetE;
        ctr_q[idx_e]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_n) begin
    if (!CPU_RST_n) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (res_act) begin
      if (BranchCount != '1) BranchCount <= BranchCount + CNT_W'(1);
      if (mispred && (MispredCount != '1)) MispredCount <= MispredCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with 4-bit statistics counters.
module tb_branch_predict_ctrl;

  localparam int CW = 4;

  logic          CPU_CLK = 1'b0;
  logic          CPU_RST_n;
  logic [31:0]   PCF;
  logic          PredTakenF;
  logic [31:0]   PredTargetF;
  logic          StallE;
  logic          IsBranchE;
  logic          BranchE;
  logic [31:0]   PCE;
  logic [31:0]   BrTargetE;
  logic          PredTakenE;
  logic          FlushMispredict;
  logic [31:0]   RedirectPC;
  logic [CW-1:0] BranchCount;
  logic [CW-1:0] MispredCount;

  int n_checks = 0;
  int n_errors = 0;

  branch_predict_ctrl #(.IDX_W(4), .TAG_W(8), .CNT_W(CW)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_n(CPU_RST_n), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .StallE(StallE), .IsBranchE(IsBranchE), .BranchE(BranchE),
    .PCE(PCE), .BrTargetE(BrTargetE), .PredTakenE(PredTakenE),
    .FlushMispredict(FlushMispredict), .RedirectPC(RedirectPC),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic res(input logic [31:0] pce, input logic br, input logic ptk,
                     input logic [31:0] tgt);
    IsBranchE  = 1'b1;
    PCE        = pce;
    BranchE    = br;
    PredTakenE = ptk;
    BrTargetE  = tgt;
    #1;
  endtask

  task automatic tick;
    @(posedge CPU_CLK);
    #1;
    IsBranchE = 1'b0;
    StallE    = 1'b0;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    PCF = pc;
    #1;
    chk({tag, "_tk"}, 32'(PredTakenF), 32'(tk));
    chk({tag, "_tgt"}, PredTargetF, tgt);
  endtask

  task automatic stats(input string tag, input int br, input int mp);
    chk({tag, "_brcnt"}, 32'(BranchCount), br);
    chk({tag, "_mpcnt"}, 32'(MispredCount), mp);
  endtask

  initial begin
    CPU_RST_n = 1'b0; PCF = 32'h100; StallE = 1'b0; IsBranchE = 1'b0;
    BranchE = 1'b0; PCE = '0; BrTargetE = '0; PredTakenE = 1'b0;
    repeat (2) @(posedge CPU_CLK);
    #1;
    look("rst", 32'h100, 1'b0, 32'h0);
    stats("rst", 0, 0);
    chk("rst_flush", 32'(FlushMispredict), 0);
    @(negedge CPU_CLK);
    CPU_RST_n = 1'b1;
    #1;

    // Cold taken branch: mispredict, allocate at weak-taken
    PCF = 32'h100;
    res(32'h100, 1'b1, 1'b0, 32'h80);
    chk("cold_flush", 32'(FlushMispredict), 1);
    chk("cold_redir", RedirectPC, 32'h80);
    chk("cold_prebypass", 32'(PredTakenF), 0);
    tick();
    chk("cold_flush_off", 32'(FlushMispredict), 0);
    chk("cold_redir_off", RedirectPC, 32'h0);
    look("cold", 32'h100, 1'b1, 32'h80);
    stats("cold", 1, 1);

    // Three correct taken resolutions: counter to strong taken
    for (int i = 0; i < 3; i++) begin
      res(32'h100, 1'b1, 1'b1, 32'h80);
      chk("hyst_noflush", 32'(FlushMispredict), 0);
      tick();
    end
    stats("hyst_t", 4, 1);

    res(32'h100, 1'b0, 1'b1, 32'h80);
    chk("hyst_nt1_flush", 32'(FlushMispredict), 1);
    chk("hyst_nt1_redir", RedirectPC, 32'h104);
    tick();
    look("hyst_nt1", 32'h100, 1'b1, 32'h80);
    stats("hyst_nt1", 5, 2);

    res(32'h100, 1'b0, 1'b1, 32'h80);
    chk("hyst_nt2_flush", 32'(FlushMispredict), 1);
    tick();
    look("hyst_nt2", 32'h100, 1'b0, 32'h0);
    stats("hyst_nt2", 6, 3);

    // Hit with taken updates target; counter weak NT -> weak T
    res(32'h100, 1'b1, 1'b0, 32'h90);
    tick();
    look("retarget", 32'h100, 1'b1, 32'h90);
    stats("retarget", 7, 4);

    // Alias: same index, different tag
    look("alias_miss", 32'h140, 1'b0, 32'h0);
    res(32'h140, 1'b1, 1'b0, 32'h200);
    chk("alias_flush", 32'(FlushMispredict), 1);
    chk("alias_redir", RedirectPC, 32'h200);
    tick();
    look("alias_hit", 32'h140, 1'b1, 32'h200);
    look("alias_evict", 32'h100, 1'b0, 32'h0);
    stats("alias", 8, 5);

    // Stalled EX: no flush, no training, no stats
    StallE = 1'b1;
    res(32'h140, 1'b0, 1'b1, 32'h0);
    chk("stall_flush", 32'(FlushMispredict), 0);
    chk("stall_redir", RedirectPC, 32'h0);
    tick();
    look("stall", 32'h140, 1'b1, 32'h200);
    stats("stall", 8, 5);

    // Not-taken miss never allocates
    res(32'h200, 1'b0, 1'b0, 32'h40);
    chk("ntmiss_flush", 32'(FlushMispredict), 0);
    tick();
    look("ntmiss", 32'h200, 1'b0, 32'h0);
    stats("ntmiss", 9, 5);

    // Saturation of both statistics counters
    for (int i = 0; i < 10; i++) begin
      res(32'h300, 1'b1, 1'b1, 32'h340);
      tick();
    end
    stats("sat_br", 15, 5);
    for (int i = 0; i < 12; i++) begin
      res(32'h400, 1'b0, 1'b1, 32'h0);
      tick();
    end
    stats("sat_mp", 15, 15);
    look("sat_entry", 32'h300, 1'b1, 32'h340);

    // Reset while a taken allocation is pending
    @(negedge CPU_CLK);
    res(32'h500, 1'b1, 1'b0, 32'h600);
    CPU_RST_n = 1'b0;
    @(posedge CPU_CLK);
    #1;
    IsBranchE = 1'b0;
    #1;
    stats("rst2", 0, 0);
    chk("rst2_flush", 32'(FlushMispredict), 0);
    look("rst2_a", 32'h140, 1'b0, 32'h0);
    look("rst2_b", 32'h300, 1'b0, 32'h0);
    @(negedge CPU_CLK);
    CPU_RST_n = 1'b1;
    #1;
    look("rst2_drop", 32'h500, 1'b0, 32'h0);
    stats("rst2_rel", 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
